// File: rtl/rvfi_pkg.sv
// rvfi_pkg: shared types and helpers for the RVFI producer.
//   rvfi_instr_t   - one RVFI retirement packet
//   rvfi_mem_rec_t - memory side-info captured from the LSU, keyed by scoreboard id
//   is_mem_op()    - instruction is a load/store (incl. FP and compressed forms)
//   is_fp_dest()   - instruction writes an FP register (rd==0 then names f0, not x0)
package rvfi_pkg;

    localparam int XLEN            = 64;
    localparam int VLEN            = 64;
    localparam int MASK_W          = XLEN / 8;
    localparam int NR_COMMIT_PORTS = 2;
    localparam int NR_SB_ENTRIES   = 8;

    typedef struct packed {
        logic              valid;
        logic [63:0]       order;
        logic [31:0]       insn;
        logic              trap;
        logic              halt;
        logic              intr;
        logic [XLEN-1:0]   cause;
        logic [1:0]        mode;
        logic [1:0]        ixl;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic [VLEN-1:0]   pc_rdata;
        logic [VLEN-1:0]   pc_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [MASK_W-1:0] mem_rmask;
        logic [MASK_W-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
    } rvfi_instr_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   addr;
        logic [MASK_W-1:0] rmask;
        logic [MASK_W-1:0] wmask;
        logic [XLEN-1:0]   wdata;
    } rvfi_mem_rec_t;

    // Compressed loads/stores live in quadrants 0 and 2 with funct3 other than 000/100.
    function automatic logic is_mem_op(input logic [31:0] insn);
        logic res;
        res = 1'b0;
        case (insn[1:0])
            2'b11: begin
                case (insn[6:0])
                    7'b0000011, 7'b0100011, 7'b0000111, 7'b0100111: res = 1'b1;
                    default:                                        res = 1'b0;
                endcase
            end
            2'b00, 2'b10: res = (insn[15:13] != 3'b000) && (insn[15:13] != 3'b100);
            default:      res = 1'b0;
        endcase
        return res;
    endfunction

    // OP-FP compares, classify/move-to-x and convert-to-int write an x register.
    function automatic logic is_fp_dest(input logic [31:0] insn);
        logic res;
        res = 1'b0;
        case (insn[1:0])
            2'b11: begin
                case (insn[6:0])
                    7'b0000111, 7'b1000011, 7'b1000111,
                    7'b1001011, 7'b1001111: res = 1'b1;
                    7'b1010011: res = (insn[31:27] != 5'b10100) && (insn[31:27] != 5'b11100)
                                   && (insn[31:27] != 5'b11000);
                    default:    res = 1'b0;
                endcase
            end
            2'b00, 2'b10: res = (insn[15:13] == 3'b001);
            default:      res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rvfi_mem_table.sv
// rvfi_mem_table: per-scoreboard-entry memory records for RVFI.
//   clk_i/rst_i      clock, async active-high reset
//   flush_i          drop all records at the next edge (same-cycle write discarded)
//   wr_valid_i/wr_id_i/wr_rec_i   LSU capture port (later write to same id overwrites)
//   rd_en_i/rd_id_i  one read+consume port per commit port
//   rd_rec_o         record seen by each commit port, bypassing a same-cycle write
module rvfi_mem_table
    import rvfi_pkg::*;
#(
    parameter int NR_PORTS   = 2,
    parameter int NR_ENTRIES = 8,
    parameter int ID_W       = $clog2(NR_ENTRIES)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     wr_valid_i,
    input  logic [ID_W-1:0]          wr_id_i,
    input  rvfi_mem_rec_t            wr_rec_i,
    input  logic [NR_PORTS-1:0]      rd_en_i,
    input  logic [NR_PORTS*ID_W-1:0] rd_id_i,
    output rvfi_mem_rec_t            rd_rec_o [NR_PORTS]
);

    rvfi_mem_rec_t table_r [NR_ENTRIES];
    rvfi_mem_rec_t table_s [NR_ENTRIES];
    logic          hit_s;
    logic          clr_s;

    // Read ports: a write to the same id in this cycle is visible to the commit.
    always_comb begin
        for (int i = 0; i < NR_PORTS; i++) begin
            if (wr_valid_i && (wr_id_i == rd_id_i[i*ID_W +: ID_W])) begin
                rd_rec_o[i]       = wr_rec_i;
                rd_rec_o[i].valid = 1'b1;
            end else begin
                rd_rec_o[i] = table_r[rd_id_i[i*ID_W +: ID_W]];
            end
        end
    end

    // Next table state: flush beats everything; a commit consumes both the
    // stored record and any same-cycle write to that id.
    always_comb begin
        hit_s = 1'b0;
        clr_s = 1'b0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            table_s[e] = table_r[e];
            hit_s      = wr_valid_i && (wr_id_i == ID_W'(e));
            clr_s      = 1'b0;
            for (int i = 0; i < NR_PORTS; i++) begin
                clr_s = clr_s | (rd_en_i[i] && (rd_id_i[i*ID_W +: ID_W] == ID_W'(e)));
            end
            if (flush_i) begin
                table_s[e].valid = 1'b0;
            end else if (hit_s) begin
                table_s[e]       = wr_rec_i;
                table_s[e].valid = ~clr_s;
            end else begin
                table_s[e].valid = table_r[e].valid & ~clr_s;
            end
        end
    end

    // Record storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                table_r[e] <= '0;
            end
        end else begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                table_r[e] <= table_s[e];
            end
        end
    end

endmodule

// File: rtl/rvfi_commit_packer.sv
// rvfi_commit_packer: builds registered RVFI packets from commit-stage info
// plus LSU memory side-info captured per scoreboard id.
//   clk_i/rst_i        clock, async active-high reset
//   flush_i            drop all captured memory records
//   lsu_*              one executed memory access per cycle, keyed by trans_id
//   commit_*           per-port retire/trap info (flat vectors, port i at slice i)
//   rvfi_o             one packet per commit port, one cycle after commit
//   mem_miss_o         a retiring load/store found no memory record
module rvfi_commit_packer
    import rvfi_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int NR_SB_ENTRIES   = 8,
    parameter int TRANS_ID_W      = $clog2(NR_SB_ENTRIES)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic                                lsu_valid_i,
    input  logic [TRANS_ID_W-1:0]               lsu_trans_id_i,
    input  logic [XLEN-1:0]                     lsu_addr_i,
    input  logic [XLEN/8-1:0]                   lsu_rmask_i,
    input  logic [XLEN/8-1:0]                   lsu_wmask_i,
    input  logic [XLEN-1:0]                     lsu_wdata_i,
    input  logic [NR_COMMIT_PORTS-1:0]          commit_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0]          commit_trap_i,
    input  logic [NR_COMMIT_PORTS*TRANS_ID_W-1:0] commit_trans_id_i,
    input  logic [NR_COMMIT_PORTS*VLEN-1:0]     commit_pc_i,
    input  logic [NR_COMMIT_PORTS*32-1:0]       commit_insn_i,
    input  logic [NR_COMMIT_PORTS*5-1:0]        commit_rd_addr_i,
    input  logic [NR_COMMIT_PORTS*XLEN-1:0]     commit_rd_wdata_i,
    input  logic [1:0]                          commit_mode_i,
    output rvfi_instr_t                         rvfi_o [NR_COMMIT_PORTS],
    output logic                                mem_miss_o
);

    rvfi_mem_rec_t wr_rec_s;
    rvfi_mem_rec_t rec_s [NR_COMMIT_PORTS];
    rvfi_instr_t   pkt_s [NR_COMMIT_PORTS];
    rvfi_instr_t   rvfi_r [NR_COMMIT_PORTS];
    logic [63:0]   order_r;
    logic [63:0]   cnt_s;
    logic          miss_s;
    logic          miss_r;
    logic          retire_s;
    logic [31:0]   insn_s;

    assign wr_rec_s = '{valid: 1'b1, addr: lsu_addr_i, rmask: lsu_rmask_i,
                        wmask: lsu_wmask_i, wdata: lsu_wdata_i};

    rvfi_mem_table #(
        .NR_PORTS   (NR_COMMIT_PORTS),
        .NR_ENTRIES (NR_SB_ENTRIES),
        .ID_W       (TRANS_ID_W)
    ) u_mem_table (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .wr_valid_i (lsu_valid_i),
        .wr_id_i    (lsu_trans_id_i),
        .wr_rec_i   (wr_rec_s),
        .rd_en_i    (commit_valid_i | commit_trap_i),
        .rd_id_i    (commit_trans_id_i),
        .rd_rec_o   (rec_s)
    );

    // Packet assembly; orders are handed out in port order to retiring ports only.
    always_comb begin
        cnt_s    = 64'd0;
        miss_s   = 1'b0;
        retire_s = 1'b0;
        insn_s   = 32'd0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            pkt_s[i] = '0;
            retire_s = commit_valid_i[i] & ~commit_trap_i[i];
            insn_s   = commit_insn_i[i*32 +: 32];
            if (commit_valid_i[i] || commit_trap_i[i]) begin
                pkt_s[i].valid    = retire_s;
                pkt_s[i].trap     = commit_trap_i[i];
                pkt_s[i].order    = order_r + cnt_s;
                pkt_s[i].pc_rdata = commit_pc_i[i*VLEN +: VLEN];
                pkt_s[i].insn     = insn_s;
                pkt_s[i].rd_addr  = commit_rd_addr_i[i*5 +: 5];
                pkt_s[i].mode     = commit_mode_i;
                // x0 never holds a value; f0 does.
                if ((commit_rd_addr_i[i*5 +: 5] == 5'd0) && !is_fp_dest(insn_s)) begin
                    pkt_s[i].rd_wdata = {XLEN{1'b0}};
                end else begin
                    pkt_s[i].rd_wdata = commit_rd_wdata_i[i*XLEN +: XLEN];
                end
                if (rec_s[i].valid) begin
                    pkt_s[i].mem_addr  = rec_s[i].addr;
                    pkt_s[i].mem_rmask = rec_s[i].rmask;
                    pkt_s[i].mem_wmask = rec_s[i].wmask;
                    pkt_s[i].mem_wdata = rec_s[i].wdata;
                end else begin
                    miss_s = miss_s | (retire_s & is_mem_op(insn_s));
                end
            end else begin
                pkt_s[i] = '0;
            end
            cnt_s = cnt_s + {63'd0, retire_s};
        end
    end

    // Output packets, miss flag and retirement order counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                rvfi_r[i] <= '0;
            end
            order_r <= 64'd0;
            miss_r  <= 1'b0;
        end else begin
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                rvfi_r[i] <= pkt_s[i];
            end
            order_r <= order_r + cnt_s;
            miss_r  <= miss_s;
        end
    end

    assign rvfi_o     = rvfi_r;
    assign mem_miss_o = miss_r;

endmodule

// File: tb/tb_rvfi_commit_packer.sv
module tb_rvfi_commit_packer;
    import rvfi_pkg::*;

    localparam logic [31:0] I_LD  = 32'h0005_3283; // ld  x5,0(x10)
    localparam logic [31:0] I_SD  = 32'h00B5_3023; // sd  x11,0(x10)
    localparam logic [31:0] I_ALU = 32'h0010_0093; // addi x1,x0,1
    localparam logic [31:0] I_NOP = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] I_FLD = 32'h0005_3007; // fld f0,0(x10)
    localparam int NV = 18;

    typedef struct packed {
        logic             lsu_v;
        logic [2:0]       lsu_id;
        logic [63:0]      lsu_addr;
        logic [7:0]       lsu_rmask;
        logic [7:0]       lsu_wmask;
        logic [63:0]      lsu_wdata;
        logic             flush;
        logic [1:0]       cv;
        logic [1:0]       ct;
        logic [1:0][2:0]  cid;
        logic [1:0][31:0] insn;
        logic [1:0][4:0]  rd;
        logic [1:0][63:0] wd;
        logic [1:0]       e_v;
        logic [1:0]       e_t;
        logic [1:0][63:0] e_order;
        logic [1:0][63:0] e_addr;
        logic [1:0][7:0]  e_rmask;
        logic [1:0][7:0]  e_wmask;
        logic [1:0][63:0] e_wdata;
        logic [1:0][63:0] e_rdw;
        logic             e_miss;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        lsu_valid = 1'b0;
    logic [2:0]  lsu_trans_id = 3'd0;
    logic [63:0] lsu_addr = 64'd0;
    logic [7:0]  lsu_rmask = 8'd0;
    logic [7:0]  lsu_wmask = 8'd0;
    logic [63:0] lsu_wdata = 64'd0;
    logic [1:0]  commit_valid = 2'd0;
    logic [1:0]  commit_trap = 2'd0;
    logic [5:0]  commit_trans_id = 6'd0;
    logic [127:0] commit_pc = 128'd0;
    logic [63:0] commit_insn = 64'd0;
    logic [9:0]  commit_rd_addr = 10'd0;
    logic [127:0] commit_rd_wdata = 128'd0;
    logic [1:0]  commit_mode = 2'b11;
    rvfi_instr_t rvfi [2];
    logic        mem_miss;

    int checks = 0;
    int errors = 0;
    vec_t tv [NV];

    rvfi_commit_packer dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .lsu_valid_i       (lsu_valid),
        .lsu_trans_id_i    (lsu_trans_id),
        .lsu_addr_i        (lsu_addr),
        .lsu_rmask_i       (lsu_rmask),
        .lsu_wmask_i       (lsu_wmask),
        .lsu_wdata_i       (lsu_wdata),
        .commit_valid_i    (commit_valid),
        .commit_trap_i     (commit_trap),
        .commit_trans_id_i (commit_trans_id),
        .commit_pc_i       (commit_pc),
        .commit_insn_i     (commit_insn),
        .commit_rd_addr_i  (commit_rd_addr),
        .commit_rd_wdata_i (commit_rd_wdata),
        .commit_mode_i     (commit_mode),
        .rvfi_o            (rvfi),
        .mem_miss_o        (mem_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pc_of(input int k, input int i);
        return 64'h1000 + 64'(k * 16) + 64'(i * 4);
    endfunction

    task automatic drive(input vec_t v, input int k);
        lsu_valid       = v.lsu_v;
        lsu_trans_id    = v.lsu_id;
        lsu_addr        = v.lsu_addr;
        lsu_rmask       = v.lsu_rmask;
        lsu_wmask       = v.lsu_wmask;
        lsu_wdata       = v.lsu_wdata;
        flush           = v.flush;
        commit_valid    = v.cv;
        commit_trap     = v.ct;
        commit_trans_id = v.cid;
        commit_insn     = v.insn;
        commit_rd_addr  = v.rd;
        commit_rd_wdata = v.wd;
        commit_pc       = {pc_of(k, 1), pc_of(k, 0)};
    endtask

    task automatic idle();
        vec_t z;
        z = '0;
        drive(z, 0);
    endtask

    initial begin
        int n;
        logic act;
        for (int k = 0; k < NV; k++) tv[k] = '0;
        // 0: capture load id 3
        tv[0].lsu_v = 1'b1; tv[0].lsu_id = 3'd3; tv[0].lsu_addr = 64'h8000_1000; tv[0].lsu_rmask = 8'hFF;
        // 2: commit load id 3 two cycles later
        tv[2].cv = 2'b01; tv[2].cid[0] = 3'd3; tv[2].insn[0] = I_LD; tv[2].rd[0] = 5'd5; tv[2].wd[0] = 64'h42;
        tv[2].e_v = 2'b01; tv[2].e_order[0] = 64'd0; tv[2].e_addr[0] = 64'h8000_1000;
        tv[2].e_rmask[0] = 8'hFF; tv[2].e_rdw[0] = 64'h42;
        // 3..5: dual ALU retirements (orders 1..6), port1 x0 write forced to 0 in 4
        for (int k = 3; k <= 5; k++) begin
            tv[k].cv = 2'b11; tv[k].insn[0] = I_ALU; tv[k].insn[1] = I_ALU;
            tv[k].rd[0] = 5'd1; tv[k].rd[1] = 5'd1;
            tv[k].wd[0] = 64'h10 + 64'(k); tv[k].wd[1] = 64'h20 + 64'(k);
            tv[k].e_v = 2'b11; tv[k].e_rdw[0] = 64'h10 + 64'(k); tv[k].e_rdw[1] = 64'h20 + 64'(k);
        end
        tv[3].cid[0] = 3'd0; tv[3].cid[1] = 3'd1; tv[3].e_order[0] = 64'd1; tv[3].e_order[1] = 64'd2;
        tv[4].cid[0] = 3'd6; tv[4].cid[1] = 3'd7; tv[4].e_order[0] = 64'd3; tv[4].e_order[1] = 64'd4;
        tv[4].insn[1] = I_NOP; tv[4].rd[1] = 5'd0; tv[4].wd[1] = 64'h99; tv[4].e_rdw[1] = 64'd0;
        tv[5].cid[0] = 3'd4; tv[5].cid[1] = 3'd5; tv[5].e_order[0] = 64'd5; tv[5].e_order[1] = 64'd6;
        // 6: store id 1 captured and committed in the same cycle
        tv[6].lsu_v = 1'b1; tv[6].lsu_id = 3'd1; tv[6].lsu_addr = 64'h100; tv[6].lsu_wmask = 8'h0F;
        tv[6].lsu_wdata = 64'hDEAD;
        tv[6].cv = 2'b01; tv[6].cid[0] = 3'd1; tv[6].insn[0] = I_SD; tv[6].rd[0] = 5'd0; tv[6].wd[0] = 64'h77;
        tv[6].e_v = 2'b01; tv[6].e_order[0] = 64'd7; tv[6].e_addr[0] = 64'h100;
        tv[6].e_wmask[0] = 8'h0F; tv[6].e_wdata[0] = 64'hDEAD; tv[6].e_rdw[0] = 64'd0;
        // 7: id 1 was consumed, so a load on it now misses
        tv[7].cv = 2'b01; tv[7].cid[0] = 3'd1; tv[7].insn[0] = I_LD; tv[7].rd[0] = 5'd5; tv[7].wd[0] = 64'h8;
        tv[7].e_v = 2'b01; tv[7].e_order[0] = 64'd8; tv[7].e_rdw[0] = 64'h8; tv[7].e_miss = 1'b1;
        // 8: port0 traps, port1 retires -> trap takes no order value
        tv[8].cv = 2'b11; tv[8].ct = 2'b01; tv[8].cid[0] = 3'd6; tv[8].cid[1] = 3'd7;
        tv[8].insn[0] = I_ALU; tv[8].insn[1] = I_ALU; tv[8].rd[0] = 5'd1; tv[8].rd[1] = 5'd1;
        tv[8].wd[0] = 64'h30; tv[8].wd[1] = 64'h31;
        tv[8].e_v = 2'b10; tv[8].e_t = 2'b01; tv[8].e_order[0] = 64'd9; tv[8].e_order[1] = 64'd9;
        tv[8].e_rdw[0] = 64'h30; tv[8].e_rdw[1] = 64'h31;
        // 9,10: capture id 2 then flush
        tv[9].lsu_v = 1'b1; tv[9].lsu_id = 3'd2; tv[9].lsu_addr = 64'h200; tv[9].lsu_rmask = 8'h0F;
        tv[10].flush = 1'b1;
        // 11: load id 2 on port1 misses; 12 idle (miss pulse gone)
        tv[11].cv = 2'b10; tv[11].cid[1] = 3'd2; tv[11].insn[1] = I_LD; tv[11].rd[1] = 5'd5; tv[11].wd[1] = 64'h7;
        tv[11].e_v = 2'b10; tv[11].e_order[1] = 64'd10; tv[11].e_rdw[1] = 64'h7; tv[11].e_miss = 1'b1;
        // 13: capture discarded by a same-cycle flush; 14 load misses
        tv[13].lsu_v = 1'b1; tv[13].lsu_id = 3'd4; tv[13].lsu_addr = 64'h400; tv[13].lsu_rmask = 8'hFF;
        tv[13].flush = 1'b1;
        tv[14].cv = 2'b01; tv[14].cid[0] = 3'd4; tv[14].insn[0] = I_LD; tv[14].rd[0] = 5'd5; tv[14].wd[0] = 64'h9;
        tv[14].e_v = 2'b01; tv[14].e_order[0] = 64'd11; tv[14].e_rdw[0] = 64'h9; tv[14].e_miss = 1'b1;
        // 15,16: capture id 5 twice (replay wins); 17 fld f0 keeps rd_wdata
        tv[15].lsu_v = 1'b1; tv[15].lsu_id = 3'd5; tv[15].lsu_addr = 64'h2F8; tv[15].lsu_rmask = 8'h0F;
        tv[16].lsu_v = 1'b1; tv[16].lsu_id = 3'd5; tv[16].lsu_addr = 64'h300; tv[16].lsu_rmask = 8'hFF;
        tv[17].cv = 2'b01; tv[17].cid[0] = 3'd5; tv[17].insn[0] = I_FLD; tv[17].rd[0] = 5'd0; tv[17].wd[0] = 64'h55;
        tv[17].e_v = 2'b01; tv[17].e_order[0] = 64'd12; tv[17].e_addr[0] = 64'h300;
        tv[17].e_rmask[0] = 8'hFF; tv[17].e_rdw[0] = 64'h55;

        // Reset state
        idle();
        repeat (2) @(negedge clk);
        chk("reset.p0.valid", {63'd0, rvfi[0].valid}, 64'd0);
        chk("reset.p1.order", rvfi[1].order, 64'd0);
        chk("reset.p0.pkt_nonzero", {63'd0, |rvfi[0]}, 64'd0);
        chk("reset.mem_miss", {63'd0, mem_miss}, 64'd0);
        rst = 1'b0;

        // Table-driven vectors
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(tv[k], k);
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                act = tv[k].cv[i] | tv[k].ct[i];
                chk($sformatf("v%0d.p%0d.valid", k, i), {63'd0, rvfi[i].valid}, {63'd0, tv[k].e_v[i]});
                chk($sformatf("v%0d.p%0d.trap", k, i), {63'd0, rvfi[i].trap}, {63'd0, tv[k].e_t[i]});
                chk($sformatf("v%0d.p%0d.order", k, i), rvfi[i].order, tv[k].e_order[i]);
                chk($sformatf("v%0d.p%0d.mem_addr", k, i), rvfi[i].mem_addr, tv[k].e_addr[i]);
                chk($sformatf("v%0d.p%0d.rmask", k, i), {56'd0, rvfi[i].mem_rmask}, {56'd0, tv[k].e_rmask[i]});
                chk($sformatf("v%0d.p%0d.wmask", k, i), {56'd0, rvfi[i].mem_wmask}, {56'd0, tv[k].e_wmask[i]});
                chk($sformatf("v%0d.p%0d.wdata", k, i), rvfi[i].mem_wdata, tv[k].e_wdata[i]);
                chk($sformatf("v%0d.p%0d.rd_wdata", k, i), rvfi[i].rd_wdata, tv[k].e_rdw[i]);
                chk($sformatf("v%0d.p%0d.pc", k, i), rvfi[i].pc_rdata, act ? pc_of(k, i) : 64'd0);
                chk($sformatf("v%0d.p%0d.insn", k, i), {32'd0, rvfi[i].insn}, act ? {32'd0, tv[k].insn[i]} : 64'd0);
                chk($sformatf("v%0d.p%0d.rd_addr", k, i), {59'd0, rvfi[i].rd_addr}, act ? {59'd0, tv[k].rd[i]} : 64'd0);
                chk($sformatf("v%0d.p%0d.mode", k, i), {62'd0, rvfi[i].mode}, act ? 64'd3 : 64'd0);
            end
            chk($sformatf("v%0d.mem_miss", k), {63'd0, mem_miss}, {63'd0, tv[k].e_miss});
        end

        // Reset while commits are pending; captured record for id 6 must not survive
        @(negedge clk);
        idle();
        n = 18;
        lsu_valid = 1'b1; lsu_trans_id = 3'd6; lsu_addr = 64'h600; lsu_rmask = 8'hFF;
        commit_valid = 2'b11; commit_trans_id = {3'd1, 3'd0};
        commit_insn = {I_ALU, I_ALU}; commit_rd_addr = {5'd1, 5'd1};
        commit_rd_wdata = {64'h2, 64'h1}; commit_pc = {pc_of(n, 1), pc_of(n, 0)};
        @(posedge clk);
        #1;
        chk("pre_rst.p0.order", rvfi[0].order, 64'd13);
        chk("pre_rst.p1.order", rvfi[1].order, 64'd14);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst.p0.valid", {63'd0, rvfi[0].valid}, 64'd0);
        chk("mid_rst.p1.order", rvfi[1].order, 64'd0);
        chk("mid_rst.p1.pc", rvfi[1].pc_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        commit_valid = 2'b01; commit_trans_id = {3'd0, 3'd6};
        commit_insn = {32'd0, I_LD}; commit_rd_addr = {5'd0, 5'd5}; commit_rd_wdata = {64'd0, 64'h1};
        @(posedge clk);
        #1;
        chk("post_rst.p0.valid", {63'd0, rvfi[0].valid}, 64'd1);
        chk("post_rst.p0.order", rvfi[0].order, 64'd0);
        chk("post_rst.p0.rmask", {56'd0, rvfi[0].mem_rmask}, 64'd0);
        chk("post_rst.mem_miss", {63'd0, mem_miss}, 64'd1);
        @(negedge clk);
        idle();
        commit_valid = 2'b11; commit_trans_id = {3'd3, 3'd2};
        commit_insn = {I_ALU, I_ALU}; commit_rd_addr = {5'd1, 5'd1};
        @(posedge clk);
        #1;
        chk("post_rst2.p0.order", rvfi[0].order, 64'd1);
        chk("post_rst2.p1.order", rvfi[1].order, 64'd2);
        chk("post_rst2.mem_miss", {63'd0, mem_miss}, 64'd0);
        @(negedge clk);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
